// File: rtl/joy_poller_if.sv
// Handshake between the frame sequencer and the joystick byte interface.
// The master side (joy_poller) requests bytes; the slave side answers with BUSY/DOUT.
interface joy_poller_if;
  logic       BUSY;
  logic [7:0] DOUT;
  logic       SNDREC;
  logic       SS_N;

  modport master (input BUSY, input DOUT, output SNDREC, output SS_N);
  modport slave  (output BUSY, output DOUT, input SNDREC, input SS_N);
endinterface

// File: rtl/joy_poller.sv
// Periodic joystick frame sequencer: polls five bytes per frame, assembles X/Y/buttons
// and emits one-shot direction events with dead-zone re-arm.
//
// state  | meaning
// IDLE   | SS_N high, waiting for a poll tick
// SETUP  | SS_N low for one cycle, byte index cleared
// REQ    | SNDREC high, waiting up to TIMEOUT cycles for BUSY
// XFER   | request accepted, waiting for BUSY to fall
// STORE  | capture DOUT into the current byte slot
// GAP    | BYTE_GAP idle cycles before the next request or the commit
// FINISH | commit positions/buttons, evaluate direction events
// ABORT  | handshake timeout, ERR pulse, nothing committed
module joy_poller #(
  parameter int POLL_DIV = 3334,
  parameter int BYTE_GAP = 2,
  parameter int HI_TH    = 700,
  parameter int LO_TH    = 300,
  parameter int TIMEOUT  = 16
) (
  input  logic         CLK,
  input  logic         RST_N,
  joy_poller_if.master byte_if,
  output logic [9:0]   X_POS,
  output logic [9:0]   Y_POS,
  output logic [2:0]   BTN,
  output logic         FRAME_VALID,
  output logic         EV_UP,
  output logic         EV_DOWN,
  output logic         EV_LEFT,
  output logic         EV_RIGHT,
  output logic         ERR
);

  localparam int              PCW       = $clog2(POLL_DIV);
  localparam logic [PCW-1:0]  POLL_LAST = PCW'(POLL_DIV - 1);
  localparam int              TW        = 16;
  localparam logic [TW-1:0]   TMR_REQ   = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0]   TMR_GAP   = TW'(BYTE_GAP - 1);
  localparam logic [9:0]      HI_V      = 10'(HI_TH);
  localparam logic [9:0]      LO_V      = 10'(LO_TH);
  localparam logic [9:0]      POS_RST   = 10'd512;

  typedef enum logic [2:0] {
    IDLE, SETUP, REQ, XFER, STORE, GAP, FINISH, ABORT
  } state_t;

  state_t         state_q, state_d;
  logic [PCW-1:0] poll_q, poll_d;
  logic [TW-1:0]  tmr_q, tmr_d;
  logic [2:0]     idx_q, idx_d;
  logic [7:0]     x_lo_q, x_lo_d, y_lo_q, y_lo_d;
  logic [1:0]     x_hi_q, x_hi_d, y_hi_q, y_hi_d;
  logic [2:0]     btn_raw_q, btn_raw_d;
  logic [9:0]     x_pos_q, x_pos_d, y_pos_q, y_pos_d;
  logic [2:0]     btn_q, btn_d;
  logic           arm_x_q, arm_x_d, arm_y_q, arm_y_d;
  logic           fv_q, fv_d;
  logic [3:0]     ev_q, ev_d;   // {up, down, left, right}

  logic       tick, tmr_done;
  logic [9:0] new_x, new_y;
  logic       x_high, x_low, y_high, y_low;
  logic       sndrec, ss_n, err;

  assign tick     = (poll_q == POLL_LAST);
  assign tmr_done = (tmr_q == '0);
  assign new_x    = {x_hi_q, x_lo_q};
  assign new_y    = {y_hi_q, y_lo_q};
  assign x_high   = (new_x > HI_V);
  assign x_low    = (new_x < LO_V);
  assign y_high   = (new_y > HI_V);
  assign y_low    = (new_y < LO_V);

  // State register
  always_ff @(posedge CLK) begin
    if (!RST_N) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; ticks outside IDLE are simply not looked at
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (tick) state_d = SETUP;
      SETUP:   state_d = REQ;
      REQ: begin
        if (byte_if.BUSY)  state_d = XFER;
        else if (tmr_done) state_d = ABORT;
      end
      XFER:    if (!byte_if.BUSY) state_d = STORE;
      STORE:   state_d = GAP;
      GAP:     if (tmr_done) state_d = (idx_q == 3'd5) ? FINISH : REQ;
      FINISH:  state_d = IDLE;
      ABORT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs decode from state; reset forces them inactive without waiting for a clock
  always_comb begin
    sndrec = 1'b0;
    ss_n   = 1'b1;
    err    = 1'b0;
    if (RST_N) begin
      case (state_q)
        SETUP, XFER, STORE, GAP: ss_n = 1'b0;
        REQ: begin
          ss_n   = 1'b0;
          sndrec = 1'b1;
        end
        ABORT:   err = 1'b1;
        default: ;
      endcase
    end
  end

  assign byte_if.SNDREC = sndrec;
  assign byte_if.SS_N   = ss_n;
  assign ERR            = err;

  // Datapath: poll counter, shared wait/gap down-counter, byte capture and commit
  always_comb begin
    poll_d    = tick ? '0 : poll_q + 1'b1;
    tmr_d     = tmr_q;
    idx_d     = idx_q;
    x_lo_d    = x_lo_q;
    x_hi_d    = x_hi_q;
    y_lo_d    = y_lo_q;
    y_hi_d    = y_hi_q;
    btn_raw_d = btn_raw_q;
    x_pos_d   = x_pos_q;
    y_pos_d   = y_pos_q;
    btn_d     = btn_q;
    arm_x_d   = arm_x_q;
    arm_y_d   = arm_y_q;
    fv_d      = 1'b0;
    ev_d      = 4'b0000;
    case (state_q)
      SETUP: begin
        idx_d = 3'd0;
        tmr_d = TMR_REQ;
      end
      REQ: if (!tmr_done) tmr_d = tmr_q - 1'b1;
      STORE: begin
        case (idx_q)
          3'd0:    x_lo_d    = byte_if.DOUT;
          3'd1:    x_hi_d    = byte_if.DOUT[1:0];
          3'd2:    y_lo_d    = byte_if.DOUT;
          3'd3:    y_hi_d    = byte_if.DOUT[1:0];
          default: btn_raw_d = byte_if.DOUT[2:0];
        endcase
        idx_d = idx_q + 3'd1;
        tmr_d = TMR_GAP;
      end
      GAP: tmr_d = tmr_done ? TMR_REQ : tmr_q - 1'b1;
      FINISH: begin
        x_pos_d = new_x;
        y_pos_d = new_y;
        btn_d   = btn_raw_q;
        fv_d    = 1'b1;
        ev_d[0] = x_high & arm_x_q;
        ev_d[1] = x_low  & arm_x_q;
        ev_d[2] = y_low  & arm_y_q;
        ev_d[3] = y_high & arm_y_q;
        // Leaving the dead zone disarms; being inside it (boundaries included) re-arms
        arm_x_d = !(x_high | x_low);
        arm_y_d = !(y_high | y_low);
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      poll_q    <= '0;
      tmr_q     <= '0;
      idx_q     <= 3'd0;
      x_lo_q    <= 8'd0;
      x_hi_q    <= 2'd0;
      y_lo_q    <= 8'd0;
      y_hi_q    <= 2'd0;
      btn_raw_q <= 3'd0;
      x_pos_q   <= POS_RST;
      y_pos_q   <= POS_RST;
      btn_q     <= 3'd0;
      arm_x_q   <= 1'b1;
      arm_y_q   <= 1'b1;
      fv_q      <= 1'b0;
      ev_q      <= 4'b0000;
    end else begin
      poll_q    <= poll_d;
      tmr_q     <= tmr_d;
      idx_q     <= idx_d;
      x_lo_q    <= x_lo_d;
      x_hi_q    <= x_hi_d;
      y_lo_q    <= y_lo_d;
      y_hi_q    <= y_hi_d;
      btn_raw_q <= btn_raw_d;
      x_pos_q   <= x_pos_d;
      y_pos_q   <= y_pos_d;
      btn_q     <= btn_d;
      arm_x_q   <= arm_x_d;
      arm_y_q   <= arm_y_d;
      fv_q      <= fv_d;
      ev_q      <= ev_d;
    end
  end

  assign X_POS       = x_pos_q;
  assign Y_POS       = y_pos_q;
  assign BTN         = btn_q;
  assign FRAME_VALID = fv_q;
  assign EV_RIGHT    = ev_q[0];
  assign EV_LEFT     = ev_q[1];
  assign EV_DOWN     = ev_q[2];
  assign EV_UP       = ev_q[3];

endmodule

// File: tb/tb_joy_poller.sv
// Scoreboard bench for joy_poller: a byte-interface model answers requests, directed frames
// push their expected commit into a queue and a monitor checks every FRAME_VALID/ERR.
module tb_joy_poller;
  localparam int P  = 128;
  localparam int TO = 16;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic [9:0] X_POS, Y_POS;
  logic [2:0] BTN;
  logic       FRAME_VALID, EV_UP, EV_DOWN, EV_LEFT, EV_RIGHT, ERR;

  always #5 CLK = ~CLK;

  joy_poller_if jif ();

  joy_poller #(.POLL_DIV(P), .BYTE_GAP(2), .HI_TH(700), .LO_TH(300), .TIMEOUT(TO)) dut (
    .CLK(CLK), .RST_N(RST_N), .byte_if(jif.master),
    .X_POS(X_POS), .Y_POS(Y_POS), .BTN(BTN), .FRAME_VALID(FRAME_VALID),
    .EV_UP(EV_UP), .EV_DOWN(EV_DOWN), .EV_LEFT(EV_LEFT), .EV_RIGHT(EV_RIGHT), .ERR(ERR)
  );

  typedef struct {
    string name;
    bit    is_err;
    int    x;
    int    y;
    int    btn;
    int    ev;   // {up, down, left, right}
  } exp_t;

  exp_t       sb[$];
  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] fb[5];
  int         busy_len = 2;
  int         hang_byte = -1;
  int         byte_cnt = 0;
  int         cyc = 0;
  int         starts[$];

  function automatic void chk(string n, int act, int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endfunction

  task automatic set_frame(input logic [7:0] b0, b1, b2, b3, b4);
    fb[0] = b0; fb[1] = b1; fb[2] = b2; fb[3] = b3; fb[4] = b4;
  endtask

  task automatic push_exp(input string n, input bit is_err, input int x, y, btn, ev);
    exp_t e;
    e.name = n; e.is_err = is_err; e.x = x; e.y = y; e.btn = btn; e.ev = ev;
    sb.push_back(e);
  endtask

  task automatic wait_drain(input string n);
    int k = 0;
    while (sb.size() != 0 && k < 4 * P + 400) begin
      @(posedge CLK);
      k++;
    end
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL %s_timeout: %0d entries still pending after %0d cycles", n, sb.size(), k);
      sb.delete();
    end
    repeat (2) @(posedge CLK);
  endtask

  task automatic run_frame(input string n, input logic [7:0] b0, b1, b2, b3, b4,
                           input int x, y, btn, ev);
    set_frame(b0, b1, b2, b3, b4);
    push_exp(n, 1'b0, x, y, btn, ev);
    wait_drain(n);
  endtask

  // Byte-interface model: raise BUSY after a request, hold it busy_len cycles, then drop
  initial begin
    jif.BUSY = 1'b0;
    jif.DOUT = 8'h00;
    forever begin
      @(posedge CLK); #1;
      if (jif.SS_N) byte_cnt = 0;
      else if (jif.SNDREC && !jif.BUSY && byte_cnt != hang_byte && byte_cnt < 5) begin
        jif.DOUT = fb[byte_cnt];
        jif.BUSY = 1'b1;
        repeat (busy_len) @(posedge CLK);
        #1;
        jif.BUSY = 1'b0;
        byte_cnt++;
      end
    end
  end

  // Frame starts must land exactly on poll ticks (multiples of P cycles after reset release)
  initial begin
    logic prev;
    prev = 1'b1;
    forever begin
      @(posedge CLK); #1;
      if (!RST_N) cyc = 0;
      else cyc++;
      if (prev && !jif.SS_N) begin
        starts.push_back(cyc);
        chk("start_phase", cyc % P, 0);
      end
      prev = jif.SS_N;
    end
  end

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (RST_N) begin
        if (FRAME_VALID || ERR) begin
          if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_output: FRAME_VALID=%0d ERR=%0d with nothing expected",
                     FRAME_VALID, ERR);
          end else begin
            e = sb.pop_front();
            chk({e.name, "_err"}, int'(ERR), int'(e.is_err));
            chk({e.name, "_fv"}, int'(FRAME_VALID), int'(!e.is_err));
            chk({e.name, "_x"}, int'(X_POS), e.x);
            chk({e.name, "_y"}, int'(Y_POS), e.y);
            chk({e.name, "_btn"}, int'(BTN), e.btn);
            chk({e.name, "_ev"}, int'({EV_UP, EV_DOWN, EV_LEFT, EV_RIGHT}), e.ev);
            if (e.is_err) chk({e.name, "_ss_n"}, int'(jif.SS_N), 1);
          end
        end else if ({EV_UP, EV_DOWN, EV_LEFT, EV_RIGHT} != 4'b0000) begin
          miscompares++;
          $display("FAIL stray_event: events=%b without FRAME_VALID",
                   {EV_UP, EV_DOWN, EV_LEFT, EV_RIGHT});
        end
      end
    end
  end

  initial begin
    int n;
    int n0;
    RST_N = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_ss_n", int'(jif.SS_N), 1);
    chk("rst_sndrec", int'(jif.SNDREC), 0);
    chk("rst_x", int'(X_POS), 512);
    chk("rst_y", int'(Y_POS), 512);
    chk("rst_btn", int'(BTN), 0);
    chk("rst_pulses", int'({FRAME_VALID, ERR, EV_UP, EV_DOWN, EV_LEFT, EV_RIGHT}), 0);

    set_frame(8'h20, 8'h03, 8'h00, 8'h02, 8'h05);
    push_exp("f1", 1'b0, 800, 512, 5, 1);
    @(negedge CLK) RST_N = 1'b1;
    n = 0;
    while (jif.SS_N && n < P + 20) begin
      @(posedge CLK); #1;
      n++;
    end
    chk("first_start", n, P);
    wait_drain("f1");

    run_frame("f2",  8'h20, 8'h03, 8'h00, 8'h02, 8'h05, 800, 512, 5, 0);
    run_frame("f3",  8'h00, 8'h02, 8'h00, 8'h02, 8'h05, 512, 512, 5, 0);
    run_frame("f4",  8'h20, 8'h03, 8'h00, 8'h02, 8'h05, 800, 512, 5, 1);
    run_frame("f5",  8'h00, 8'h02, 8'h00, 8'h02, 8'h05, 512, 512, 5, 0);
    run_frame("f6",  8'hFA, 8'hFC, 8'hBD, 8'h02, 8'hF8, 250, 701, 0, 10);
    run_frame("f7",  8'h2C, 8'h01, 8'hBD, 8'h02, 8'h02, 300, 701, 2, 0);
    run_frame("f8",  8'hFF, 8'h03, 8'h00, 8'h00, 8'h00, 1023, 0, 0, 1);
    run_frame("f9",  8'hBC, 8'h02, 8'h2C, 8'h01, 8'h06, 700, 300, 6, 0);
    run_frame("f10", 8'hBD, 8'h02, 8'h2B, 8'h01, 8'h01, 701, 299, 1, 5);

    // BUSY never answers the request for byte index 3
    set_frame(8'h11, 8'h01, 8'h22, 8'h02, 8'h07);
    hang_byte = 3;
    push_exp("abort", 1'b1, 701, 299, 1, 0);
    n = 0;
    while (!(jif.SNDREC && byte_cnt == 3) && n < 2 * P + 200) begin
      @(posedge CLK); #1;
      n++;
    end
    n = 0;
    while (jif.SNDREC && n < 4 * TO) begin
      @(posedge CLK); #1;
      n++;
    end
    chk("timeout_len", n, TO);
    wait_drain("abort");
    hang_byte = -1;

    run_frame("f11", 8'h20, 8'h03, 8'h00, 8'h02, 8'h05, 800, 512, 5, 0);

    // Reset while byte 2 is in flight
    set_frame(8'h64, 8'h00, 8'h64, 8'h00, 8'h00);
    n = 0;
    while (!(byte_cnt == 2 && jif.BUSY) && n < 2 * P + 200) begin
      @(posedge CLK); #1;
      n++;
    end
    @(negedge CLK) RST_N = 1'b0;
    #1;
    chk("midrst_ss_n", int'(jif.SS_N), 1);
    chk("midrst_sndrec", int'(jif.SNDREC), 0);
    @(posedge CLK); #1;
    chk("midrst_x", int'(X_POS), 512);
    chk("midrst_y", int'(Y_POS), 512);
    chk("midrst_btn", int'(BTN), 0);
    chk("midrst_fv", int'(FRAME_VALID), 0);
    repeat (2) @(posedge CLK);
    @(negedge CLK) RST_N = 1'b1;

    run_frame("f13", 8'h20, 8'h03, 8'h00, 8'h02, 8'h05, 800, 512, 5, 1);

    // Stretched BUSY makes this frame longer than P; the tick inside it must be dropped
    n0 = starts.size();
    busy_len = 30;
    run_frame("f14", 8'h00, 8'h02, 8'h00, 8'h02, 8'h00, 512, 512, 0, 0);
    busy_len = 2;
    run_frame("f15", 8'h00, 8'h00, 8'hFF, 8'h03, 8'h07, 0, 1023, 7, 10);
    if (starts.size() >= n0 + 2) chk("stretch_gap", starts[n0 + 1] - starts[n0], 2 * P);
    else begin
      miscompares++;
      $display("FAIL stretch_gap: only %0d frame starts seen, required %0d", starts.size() - n0, 2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/joy_poller.md
Name: joy_poller

Overview:
Periodic frame sequencer downstream of the joystick byte interface. It strobes the interface's SNDREC/BUSY handshake five times per frame while holding the joystick slave select low. It assembles the received bytes into 10-bit X/Y positions and 3 button bits. It then produces one-shot direction events with re-arm hysteresis for the parking-meter UI logic.

Parameters:
POLL_DIV, 3334, CLK cycles between frame starts (~50 ms at 66.67 kHz); minimum 64
BYTE_GAP, 2, idle CLK cycles between byte requests inside a frame, SS_N held low; minimum 1
HI_TH, 700, axis value strictly above this -> positive direction event
LO_TH, 300, axis value strictly below this -> negative direction event
TIMEOUT, 16, max CLK cycles to wait for BUSY to rise after SNDREC is raised

Ports:
CLK  in  1  system clock, same 66.67 kHz clock as the byte interface; all logic on posedge
RST_N  in  1  synchronous active-low reset
BUSY  in  1  from byte interface
DOUT  in  8  received byte from byte interface
SNDREC  out  1  request to byte interface
SS_N  out  1  joystick slave select, active low
X_POS  out  10  last valid X position
Y_POS  out  10  last valid Y position
BTN  out  3  last valid buttons {trigger, jsbtn1, jsbtn0} = byte4[2:0]
FRAME_VALID  out  1  one-cycle pulse when a new frame is committed
EV_UP, EV_DOWN, EV_LEFT, EV_RIGHT  out  1 each  one-cycle direction event pulses
ERR  out  1  one-cycle pulse on handshake timeout

Behaviour:
- Reset (RST_N=0 at posedge) values: SNDREC=0, SS_N=1, X_POS=Y_POS=512, BTN=0, all pulses 0, state IDLE, poll counter 0, byte index 0, both axis arm flags 1.
- Reset mid-frame: outputs return to the reset values above on the next posedge; SS_N goes high immediately; no partial frame is committed.
- Poll counter: free-running 0..POLL_DIV-1. Tick when count = POLL_DIV-1. A tick is acted on only in IDLE; ticks seen in any other state are dropped without queuing. The first frame starts POLL_DIV cycles after reset release.
- FSM:
  - IDLE: SS_N=1. On tick -> SETUP.
  - SETUP: SS_N=0 for one cycle; idx=0 -> REQ.
  - REQ: SNDREC=1; wait counter runs. BUSY=1 -> XFER. If TIMEOUT cycles elapse with BUSY=0 -> ABORT.
  - XFER: SNDREC=0. Wait for BUSY=0 -> STORE.
  - STORE: byte[idx]<=DOUT; idx<=idx+1 -> GAP.
  - GAP: count BYTE_GAP cycles, then REQ if idx<5, else FINISH.
  - FINISH: SS_N=1; commit X_POS={byte1[1:0],byte0}, Y_POS={byte3[1:0],byte2}, BTN=byte4[2:0]; FRAME_VALID=1 for this cycle; evaluate events -> IDLE.
  - ABORT: SS_N=1, SNDREC=0, ERR=1 for one cycle; outputs are retained and not committed -> IDLE.
- SS_N is low continuously from SETUP through the last GAP, with no glitch between bytes.
- Handshake:
  - SNDREC stays high until BUSY is sampled high, then drops.
  - DOUT is sampled only in STORE, i.e. after BUSY is seen falling.
  - If BUSY is already high on entering REQ, the request counts as accepted in that cycle.
- Events are evaluated in FINISH on the newly assembled values and pulse in the same cycle as FRAME_VALID:
  - X: X>HI_TH and armX -> EV_RIGHT, armX<=0. X<LO_TH and armX -> EV_LEFT, armX<=0. LO_TH<=X<=HI_TH -> armX<=1.
  - Y: same rule with EV_UP for high and EV_DOWN for low, using armY.
  - X and Y are independent; an X event and a Y event may pulse in the same cycle.
  - Boundary values HI_TH and LO_TH are inside the dead zone and re-arm.
  - An axis that moves from high to low directly across frames without passing the dead zone produces no event.
- Comparisons are unsigned 10-bit. The byte1/byte3 bits [7:2] are ignored.

Test Plan:
- Reset, model the interface returning bytes 0x20,0x03,0x00,0x02,0x05 -> after POLL_DIV cycles SS_N falls; five SNDREC/BUSY handshakes; FRAME_VALID with X_POS=800, Y_POS=512, BTN=3'b101; EV_RIGHT pulses once in the same cycle, no other events.
- Repeat the same frame twice, then send X=512 frame, then X=800 again -> EV_RIGHT on frame 1 only, not frame 2, again on frame 4.
- Frame with X=250, Y=701 -> EV_LEFT and EV_UP pulse in the same cycle; X=300 next frame -> re-arm, no event.
- Hold BUSY low after SNDREC on byte 3 -> after 16 cycles ERR pulses, SS_N=1, X/Y/BTN unchanged, no FRAME_VALID; the next tick starts a clean frame.
- Assert RST_N=0 during byte 2 of a frame -> next posedge SS_N=1, SNDREC=0, X_POS=512; the frame is not committed.
- Stretch BUSY so a frame exceeds POLL_DIV -> the overlapping tick is dropped; the next frame starts on the following tick; no back-to-back frames.
